// File: rtl/cpc_ram_pkg.sv
// CPC RAM expansion MMU shared types and tables.
// Optional bus reset input: define CPC_RAM_BUSRESET_EN.
package cpc_ram_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } cap_state_t;

  // Map entry: {hit, page[1:0]}
  typedef logic [2:0] map_ent_t;

  localparam map_ent_t MAP_B  = 3'b000;
  localparam map_ent_t MAP_E0 = 3'b100;
  localparam map_ent_t MAP_E1 = 3'b101;
  localparam map_ent_t MAP_E2 = 3'b110;
  localparam map_ent_t MAP_E3 = 3'b111;

  localparam logic [1:0] PORT_MATCH = 2'b11;

  // Indexed [cfg][region]; region = {A15,A14}
  localparam logic [0:7][0:3][2:0] RAM_MAP = {
    {MAP_B,  MAP_B,  MAP_B,  MAP_B },
    {MAP_B,  MAP_B,  MAP_B,  MAP_E3},
    {MAP_E0, MAP_E1, MAP_E2, MAP_E3},
    {MAP_B,  MAP_B,  MAP_B,  MAP_E3},
    {MAP_B,  MAP_E0, MAP_B,  MAP_B },
    {MAP_B,  MAP_E1, MAP_B,  MAP_B },
    {MAP_B,  MAP_E2, MAP_B,  MAP_B },
    {MAP_B,  MAP_E3, MAP_B,  MAP_B }
  };

endpackage

// File: rtl/cpc_ram_bank_map.sv
// Combinational region decode: config + block + address -> hit, SRAM high address.
// Part of cpc_ram_mmu (optional CPC_RAM_BUSRESET_EN lives in the top).
module cpc_ram_bank_map
  import cpc_ram_pkg::*;
(
  input  logic [2:0] cfg,
  input  logic [2:0] blk,
  input  logic       a15,
  input  logic       a14,
  output logic       hit,
  output logic [4:0] hiadr
);

  map_ent_t ent;

  assign ent   = RAM_MAP[cfg][{a15, a14}];
  assign hit   = ent[2];
  assign hiadr = {blk, ent[1:0]};

endmodule

// File: rtl/cpc_ram_mmu.sv
// CPC RAM expansion MMU: config port capture and SRAM strobe decode.
// Define CPC_RAM_BUSRESET_EN to add the BUSRESET_B clear input.
module cpc_ram_mmu
  import cpc_ram_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
`ifdef CPC_RAM_BUSRESET_EN
  input  logic       BUSRESET_B,
`endif
  input  logic       A15,
  input  logic       A14,
  input  logic       A8,
  input  logic [7:0] D,
  input  logic       MREQ_B,
  input  logic       IOREQ_B,
  input  logic       RD_B,
  input  logic       WR_B,
  input  logic       M1_B,
  input  logic       RAMRD_B,
  output logic [4:0] HIADR,
  output logic       RAMCS_B,
  output logic       RAMOE_B,
  output logic       RAMWE_B,
  output logic       RAMDIS,
  output logic [2:0] CFG,
  output logic [2:0] BLK
);

  cap_state_t state_q;
  cap_state_t state_d;
  logic [2:0] cfg_q;
  logic [2:0] blk_q;
  logic [4:0] hiadr_q;
  logic       strobe_q;
  logic       clr;
  logic       io_wr;
  logic       cfg_wr;
  logic       capture;
  logic       map_hit;
  logic [4:0] map_adr;
  logic       mem_sel;
  logic       ram_cs;
  logic       unused_a8;

  assign unused_a8 = A8;

`ifdef CPC_RAM_BUSRESET_EN
  assign clr = RESET | ~BUSRESET_B;
`else
  assign clr = RESET;
`endif

  assign io_wr  = ~IOREQ_B & ~WR_B;
  assign cfg_wr = io_wr & M1_B & ~A15
                & (D[7:6] == PORT_MATCH);

  // strobe_q blocks a write still held across reset release
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_wr && !strobe_q) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (IOREQ_B || WR_B) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    strobe_q <= io_wr;
    if (clr) begin
      state_q <= IDLE;
      cfg_q   <= 3'd0;
      blk_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        cfg_q <= D[2:0];
        blk_q <= D[5:3];
      end
    end
    if (RESET) begin
      hiadr_q <= 5'd0;
    end else if (map_hit) begin
      hiadr_q <= map_adr;
    end
  end

  cpc_ram_bank_map u_map (
    .cfg   (cfg_q),
    .blk   (blk_q),
    .a15   (A15),
    .a14   (A14),
    .hit   (map_hit),
    .hiadr (map_adr)
  );

  assign mem_sel = ~MREQ_B & map_hit & ~RESET;
  assign ram_cs  = mem_sel & (~RD_B | ~WR_B);

  assign RAMCS_B = ~ram_cs;
  assign RAMWE_B = ~(ram_cs & ~WR_B);
  assign RAMOE_B = ~(ram_cs & ~RAMRD_B & WR_B);
  assign RAMDIS  = mem_sel;
  assign HIADR   = map_hit ? map_adr : hiadr_q;
  assign CFG     = cfg_q;
  assign BLK     = blk_q;

endmodule

// File: tb/tb_cpc_ram_mmu.sv
// Directed scoreboard bench for cpc_ram_mmu.
// Builds with or without CPC_RAM_BUSRESET_EN.
module tb_cpc_ram_mmu;

  typedef struct packed {
    logic [4:0] hiadr;
    logic       cs_b;
    logic       oe_b;
    logic       we_b;
    logic       dis;
    logic [2:0] cfg;
    logic [2:0] blk;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       A15, A14, A8;
  logic [7:0] D;
  logic       MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RAMRD_B;
  logic [4:0] HIADR;
  logic       RAMCS_B, RAMOE_B, RAMWE_B, RAMDIS;
  logic [2:0] CFG, BLK;
`ifdef CPC_RAM_BUSRESET_EN
  logic       BUSRESET_B = 1'b1;
`endif

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 CLK = ~CLK;

  cpc_ram_mmu dut (
    .CLK        (CLK),
    .RESET      (RESET),
`ifdef CPC_RAM_BUSRESET_EN
    .BUSRESET_B (BUSRESET_B),
`endif
    .A15        (A15),
    .A14        (A14),
    .A8         (A8),
    .D          (D),
    .MREQ_B     (MREQ_B),
    .IOREQ_B    (IOREQ_B),
    .RD_B       (RD_B),
    .WR_B       (WR_B),
    .M1_B       (M1_B),
    .RAMRD_B    (RAMRD_B),
    .HIADR      (HIADR),
    .RAMCS_B    (RAMCS_B),
    .RAMOE_B    (RAMOE_B),
    .RAMWE_B    (RAMWE_B),
    .RAMDIS     (RAMDIS),
    .CFG        (CFG),
    .BLK        (BLK)
  );

  task automatic bus(
    input logic       rst,
    input logic       mreq,
    input logic       ioreq,
    input logic       rd,
    input logic       wr,
    input logic       m1,
    input logic       ramrd,
    input logic [1:0] a,
    input logic [7:0] d
  );
    @(negedge CLK);
    RESET   = rst;
    MREQ_B  = mreq;
    IOREQ_B = ioreq;
    RD_B    = rd;
    WR_B    = wr;
    M1_B    = m1;
    RAMRD_B = ramrd;
    A15     = a[1];
    A14     = a[0];
    A8      = 1'($urandom_range(1));
    D       = d;
  endtask

  task automatic idle();
    bus(0, 1, 1, 1, 1, 1, 1, 2'b00, 8'h00);
  endtask

  // ctl = {RAMCS_B, RAMOE_B, RAMWE_B, RAMDIS}
  task automatic chk(
    input string      tag,
    input logic [4:0] h,
    input logic [3:0] ctl,
    input logic [2:0] c,
    input logic [2:0] b
  );
    exp_t e;
    exp_t p;
    obs_t got;
    e.tag = tag;
    e.v   = {h, ctl, c, b};
    sb.push_back(e);
    #2;
    p   = sb.pop_front();
    got = {HIADR, RAMCS_B, RAMOE_B, RAMWE_B, RAMDIS, CFG, BLK};
    vectors++;
    assert (got === p.v) else begin
      miscompares++;
      $error("FAIL %s: got hiadr=%b ctl=%b cfg=%0d blk=%0d want hiadr=%b ctl=%b cfg=%0d blk=%0d",
             p.tag, got.hiadr, {got.cs_b, got.oe_b, got.we_b, got.dis},
             got.cfg, got.blk, p.v.hiadr,
             {p.v.cs_b, p.v.oe_b, p.v.we_b, p.v.dis}, p.v.cfg, p.v.blk);
    end
  endtask

  initial begin
    RESET = 1'b1;
    MREQ_B = 1'b1; IOREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1;
    M1_B = 1'b1; RAMRD_B = 1'b1;
    A15 = 1'b0; A14 = 1'b0; A8 = 1'b0; D = 8'h00;

    bus(1, 1, 1, 1, 1, 1, 1, 2'b00, 8'h00);
    chk("reset", 5'b00000, 4'b1110, 3'd0, 3'd0);

    bus(0, 0, 1, 0, 1, 1, 0, 2'b11, 8'h00);
    chk("rd_c000_c0", 5'b00000, 4'b1110, 3'd0, 3'd0);

    bus(0, 1, 0, 1, 0, 1, 1, 2'b00, 8'hC2);
    chk("io_c2", 5'b00000, 4'b1110, 3'd0, 3'd0);
    bus(0, 0, 1, 0, 1, 1, 0, 2'b01, 8'h00);
    chk("rd_4000_c2", 5'b00001, 4'b0011, 3'd2, 3'd0);

    bus(0, 1, 0, 1, 0, 1, 1, 2'b00, 8'hFC);
    chk("io_fc", 5'b00000, 4'b1110, 3'd2, 3'd0);
    bus(0, 0, 1, 1, 0, 1, 1, 2'b01, 8'h00);
    chk("wr_7fff_c4", 5'b11100, 4'b0101, 3'd4, 3'd7);
    bus(0, 0, 1, 1, 0, 1, 1, 2'b11, 8'h00);
    chk("wr_c000_miss", 5'b11100, 4'b1110, 3'd4, 3'd7);
    bus(0, 0, 1, 0, 0, 1, 0, 2'b01, 8'h00);
    chk("rd_wr_both", 5'b11100, 4'b0101, 3'd4, 3'd7);

    bus(0, 1, 0, 1, 0, 1, 1, 2'b00, 8'hC7);
    chk("io_c7_hold0", 5'b11100, 4'b1110, 3'd4, 3'd7);
    for (int i = 0; i < 4; i++) begin
      bus(0, 1, 0, 1, 0, 1, 1, 2'b00, 8'hC1);
      chk("io_c7_held", 5'b11100, 4'b1110, 3'd7, 3'd0);
    end
    idle();
    chk("c7_release", 5'b11100, 4'b1110, 3'd7, 3'd0);

    bus(0, 1, 0, 1, 0, 0, 1, 2'b00, 8'hC2);
    chk("inta", 5'b11100, 4'b1110, 3'd7, 3'd0);
    idle();
    chk("inta_after", 5'b11100, 4'b1110, 3'd7, 3'd0);
    bus(0, 1, 0, 1, 0, 1, 1, 2'b10, 8'hC2);
    chk("io_a15", 5'b11100, 4'b1110, 3'd7, 3'd0);
    idle();
    chk("io_a15_after", 5'b11100, 4'b1110, 3'd7, 3'd0);
    bus(0, 1, 0, 1, 0, 1, 1, 2'b00, 8'h82);
    chk("io_82", 5'b11100, 4'b1110, 3'd7, 3'd0);
    idle();
    chk("io_82_after", 5'b11100, 4'b1110, 3'd7, 3'd0);

    bus(0, 0, 1, 0, 1, 1, 1, 2'b01, 8'h00);
    chk("rom_overlay", 5'b00011, 4'b0111, 3'd7, 3'd0);

    bus(0, 1, 0, 1, 0, 1, 1, 2'b00, 8'hC5);
    chk("io_c5", 5'b00011, 4'b1110, 3'd7, 3'd0);
    bus(1, 0, 0, 0, 0, 1, 0, 2'b01, 8'hC5);
    chk("rst_in_hold", 5'b00001, 4'b1110, 3'd5, 3'd0);
    bus(1, 0, 0, 0, 0, 1, 0, 2'b01, 8'hC5);
    chk("rst_cleared", 5'b00000, 4'b1110, 3'd0, 3'd0);
    bus(0, 1, 0, 1, 0, 1, 1, 2'b00, 8'hC5);
    chk("rel_held0", 5'b00000, 4'b1110, 3'd0, 3'd0);
    bus(0, 1, 0, 1, 0, 1, 1, 2'b00, 8'hC5);
    chk("rel_held1", 5'b00000, 4'b1110, 3'd0, 3'd0);
    idle();
    chk("rel_idle", 5'b00000, 4'b1110, 3'd0, 3'd0);
    bus(0, 1, 0, 1, 0, 1, 1, 2'b00, 8'hC5);
    chk("fresh_c5", 5'b00000, 4'b1110, 3'd0, 3'd0);
    idle();
    chk("fresh_after", 5'b00000, 4'b1110, 3'd5, 3'd0);
    bus(0, 0, 1, 0, 1, 1, 0, 2'b01, 8'h00);
    chk("rd_4000_c5", 5'b00001, 4'b0011, 3'd5, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
